// File: rtl/hazard_detect_unit_if.sv
// Pipeline-to-hazard-unit bundle: stage operand/control taps in, stall/flush controls
// and debug statistics out.
interface hazard_detect_unit_if #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             branchOp;
  logic             branch;
  logic             D_Xmem_R;
  logic             X_Mmem_R;
  logic             X_Mreg_W;
  logic             M_Wmem_R;
  logic [REG_W-1:0] D_Xop1;
  logic [REG_W-1:0] F_Dop1;
  logic [REG_W-1:0] F_Dop2;
  logic [REG_W-1:0] X_Mop1;
  logic [REG_W-1:0] M_Wop1;
  logic             bubble;
  logic             F_Dwrite;
  logic             PCwrite;
  logic [2:0]       hzd_cause;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output branchOp, branch, D_Xmem_R, X_Mmem_R, X_Mreg_W, M_Wmem_R,
    output D_Xop1, F_Dop1, F_Dop2, X_Mop1, M_Wop1,
    input  bubble, F_Dwrite, PCwrite, hzd_cause, stall_cnt, flush_cnt
  );

  modport slave (
    input  branchOp, branch, D_Xmem_R, X_Mmem_R, X_Mreg_W, M_Wmem_R,
    input  D_Xop1, F_Dop1, F_Dop2, X_Mop1, M_Wop1,
    output bubble, F_Dwrite, PCwrite, hzd_cause, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_detect_unit.sv
// Hazard detection for the F/D/X/M/W pipeline: combinational stall/flush controls plus
// a registered cause code and saturating stall/flush statistics counters.
module hazard_detect_unit #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_detect_unit_if.slave hz
);

  typedef enum logic [2:0] {
    CauseNone  = 3'd0,
    CauseLu    = 3'd1,
    CauseBa    = 3'd2,
    CauseBl1   = 3'd3,
    CauseBl2   = 3'd4,
    CauseFlush = 3'd5
  } cause_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [REG_W-1:0] d_x_op1, f_d_op1, f_d_op2, x_m_op1, m_w_op1;
  logic             lu, ba, bl1, bl2, stall, flush;
  cause_e           cause_d, cause_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign d_x_op1 = hz.D_Xop1;
  assign f_d_op1 = hz.F_Dop1;
  assign f_d_op2 = hz.F_Dop2;
  assign x_m_op1 = hz.X_Mop1;
  assign m_w_op1 = hz.M_Wop1;

  assign lu    = hz.D_Xmem_R & ((d_x_op1 == f_d_op1) | (d_x_op1 == f_d_op2));
  assign ba    = hz.branchOp & hz.X_Mreg_W & (x_m_op1 == f_d_op1);
  assign bl1   = hz.branchOp & hz.X_Mmem_R & (x_m_op1 == f_d_op1);
  assign bl2   = hz.branchOp & hz.M_Wmem_R & (m_w_op1 == f_d_op1);
  assign stall = lu | ba | bl1 | bl2;
  assign flush = hz.branch;

  // Flush wins over stall: the younger instructions are being squashed anyway.
  always_comb begin
    hz.bubble   = 1'b0;
    hz.F_Dwrite = 1'b1;
    hz.PCwrite  = 1'b1;
    if (rst_n) begin
      if (flush) begin
        hz.bubble = 1'b1;
      end else if (stall) begin
        hz.bubble   = 1'b1;
        hz.F_Dwrite = 1'b0;
        hz.PCwrite  = 1'b0;
      end
    end
  end

  always_comb begin
    cause_d = CauseNone;
    if (flush)    cause_d = CauseFlush;
    else if (lu)  cause_d = CauseLu;
    else if (ba)  cause_d = CauseBa;
    else if (bl1) cause_d = CauseBl1;
    else if (bl2) cause_d = CauseBl2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q     <= CauseNone;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cause_q <= cause_d;
      if (stall && !flush && stall_cnt_q != CntMax) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && flush_cnt_q != CntMax)           flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.hzd_cause = cause_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit; narrow counters so saturation is reachable.
module tb_hazard_detect_unit;
  localparam int unsigned RegW = 4;
  localparam int unsigned CntW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hazard_detect_unit_if #(.REG_W(RegW), .CNT_W(CntW)) hz ();

  hazard_detect_unit #(.REG_W(RegW), .CNT_W(CntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic b, input logic fdw, input logic pcw);
    chk({tag, ".bubble"}, {31'd0, hz.bubble}, {31'd0, b});
    chk({tag, ".F_Dwrite"}, {31'd0, hz.F_Dwrite}, {31'd0, fdw});
    chk({tag, ".PCwrite"}, {31'd0, hz.PCwrite}, {31'd0, pcw});
  endtask

  task automatic chk_reg(input string tag, input int cause, input int sc, input int fc);
    chk({tag, ".cause"}, {29'd0, hz.hzd_cause}, cause);
    chk({tag, ".stall_cnt"}, {30'd0, hz.stall_cnt}, sc);
    chk({tag, ".flush_cnt"}, {30'd0, hz.flush_cnt}, fc);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    hz.branchOp = 0; hz.branch = 0; hz.D_Xmem_R = 0; hz.X_Mmem_R = 0;
    hz.X_Mreg_W = 0; hz.M_Wmem_R = 0;
    hz.F_Dop1 = 4'd1; hz.F_Dop2 = 4'd2; hz.D_Xop1 = 4'd0; hz.X_Mop1 = 4'd3; hz.M_Wop1 = 4'd4;
    #2;
    chk_reg("reset", 0, 0, 0);
    chk_ctl("reset", 0, 1, 1);
    #10 rst_n = 1'b1;

    // 1: no hazard
    #1 chk_ctl("idle", 0, 1, 1);
    step();
    chk_reg("idle", 0, 0, 0);

    // 2: load-use on op1, op2, then a non-matching load
    hz.D_Xmem_R = 1; hz.F_Dop1 = 4'd0;
    #1 chk_ctl("lu_op1", 1, 0, 0);
    step();
    chk_reg("lu_op1", 1, 1, 0);
    hz.F_Dop1 = 4'd1; hz.F_Dop2 = 4'd0;
    #1 chk_ctl("lu_op2", 1, 0, 0);
    step();
    chk_reg("lu_op2", 1, 2, 0);
    hz.F_Dop2 = 4'd2;
    #1 chk_ctl("lu_miss", 0, 1, 1);
    step();
    chk_reg("lu_miss", 0, 2, 0);
    hz.D_Xmem_R = 0;
    pulse_reset();

    // 3: branch after ALU op
    hz.branchOp = 1; hz.X_Mreg_W = 1; hz.X_Mop1 = 4'd1;
    #1 chk_ctl("ba", 1, 0, 0);
    step();
    chk_reg("ba", 2, 1, 0);
    hz.X_Mop1 = 4'd3;
    #1 chk_ctl("ba_miss", 0, 1, 1);
    step();
    chk_reg("ba_miss", 0, 1, 0);
    hz.X_Mop1 = 4'd1; hz.X_Mreg_W = 0;
    #1 chk_ctl("ba_nowr", 0, 1, 1);
    step();
    chk_reg("ba_nowr", 0, 1, 0);

    // 4: branch after load in X/M, then in M/W, then no branch
    hz.X_Mmem_R = 1;
    #1 chk_ctl("bl1", 1, 0, 0);
    step();
    chk_reg("bl1", 3, 2, 0);
    hz.X_Mmem_R = 0; hz.M_Wmem_R = 1; hz.M_Wop1 = 4'd1;
    #1 chk_ctl("bl2", 1, 0, 0);
    step();
    chk_reg("bl2", 4, 3, 0);
    hz.branchOp = 0;
    #1 chk_ctl("bl2_nobr", 0, 1, 1);
    step();
    chk_reg("bl2_nobr", 0, 3, 0);
    hz.M_Wmem_R = 0;
    pulse_reset();

    // 5: flush concurrent with load-use
    hz.D_Xmem_R = 1; hz.D_Xop1 = 4'd1; hz.branch = 1;
    #1 chk_ctl("flush_lu", 1, 1, 1);
    step();
    chk_reg("flush_lu", 5, 0, 1);
    hz.branch = 0;

    // 6: saturation, then asynchronous reset mid-stall
    for (int i = 0; i < 5; i++) step();
    chk_reg("sat", 1, 3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reg("async_rst", 0, 0, 0);
    chk_ctl("async_rst", 0, 1, 1);
    #2 rst_n = 1'b1;
    #1 chk_ctl("post_rst", 1, 0, 0);
    step();
    chk_reg("post_rst", 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Hazard detection unit for the 5-stage (F/D/X/M/W) pipelined datapath.
- Combinationally compares source operands in the F/D register against destination operands in later stages.
- Outputs drive bubble insertion, the F/D register write enable and the PC write enable.
- Clocked saturating counters and a registered cause code record hazard activity for debug and performance monitoring.

Parameters:
- REG_W, 4, width of register-specifier operands.
- CNT_W, 16, width of the stall and flush statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- branchOp  input  1  instruction in F/D is a branch; it reads F_Dop1 in decode.
- branch  input  1  branch resolved taken this cycle; flush request.
- D_Xmem_R  input  1  instruction in D/X is a load.
- X_Mmem_R  input  1  instruction in X/M is a load.
- X_Mreg_W  input  1  instruction in X/M writes a register.
- M_Wmem_R  input  1  instruction in M/W is a load.
- D_Xop1  input  REG_W  destination register of D/X.
- F_Dop1  input  REG_W  source operand 1 of F/D.
- F_Dop2  input  REG_W  source operand 2 of F/D.
- X_Mop1  input  REG_W  destination register of X/M.
- M_Wop1  input  REG_W  destination register of M/W.
- bubble  output  1  zero the control signals entering D/X (insert NOP).
- F_Dwrite  output  1  F/D register write enable.
- PCwrite  output  1  PC write enable.
- hzd_cause  output  3  registered cause code of the last cycle.
- stall_cnt  output  CNT_W  number of stall cycles.
- flush_cnt  output  CNT_W  number of flush cycles.

Behaviour:
Hazard terms (combinational). Register 0 is not special; equal specifiers always match.
- LU (load-use) = D_Xmem_R & (D_Xop1==F_Dop1 | D_Xop1==F_Dop2).
- BA (branch after ALU op) = branchOp & X_Mreg_W & (X_Mop1==F_Dop1).
- BL1 (branch after load in X/M) = branchOp & X_Mmem_R & (X_Mop1==F_Dop1).
- BL2 (branch after load in M/W) = branchOp & M_Wmem_R & (M_Wop1==F_Dop1).
- STALL = LU | BA | BL1 | BL2.
- FLUSH = branch.

Output priority (combinational, zero latency, rst_n high):
1. FLUSH has priority over STALL: bubble=1, F_Dwrite=1, PCwrite=1.
2. Otherwise, if STALL: bubble=1, F_Dwrite=0, PCwrite=0.
3. Otherwise: bubble=0, F_Dwrite=1, PCwrite=1.

While rst_n=0, outputs are forced to bubble=0, F_Dwrite=1, PCwrite=1, independent of the inputs.

hzd_cause encoding (priority order):
- 5 = FLUSH
- 1 = LU
- 2 = BA
- 3 = BL1
- 4 = BL2
- 0 = none
- hzd_cause is registered on the rising clk edge, so it shows the previous cycle's cause (latency 1).

Counters:
- stall_cnt increments on each rising edge where STALL & ~FLUSH.
- flush_cnt increments on each rising edge where FLUSH.
- Both saturate at 2^CNT_W-1 and never wrap.

Reset:
- Asynchronous assertion of rst_n=0 immediately clears hzd_cause, stall_cnt and flush_cnt to 0, including mid-stall.
- Counting resumes on the first rising edge after rst_n deasserts.

Other rules:
- Multiple simultaneous hazards produce a single stall; each counter increments at most once per cycle.
- No internal state influences bubble, F_Dwrite or PCwrite; they are a pure function of the current inputs.

Test Plan:
1. All controls 0; F_Dop1=1, F_Dop2=2, D_Xop1=0, X_Mop1=3, M_Wop1=4 -> bubble=0, F_Dwrite=1, PCwrite=1; hzd_cause=0 after the edge.
2. D_Xmem_R=1 with F_Dop1=0, then F_Dop1=1 and F_Dop2=0 -> bubble=1, F_Dwrite=0, PCwrite=0 in both cases; hzd_cause=1; stall_cnt +1 per cycle. D_Xmem_R=1 with F_Dop2=2 (no match) -> no stall.
3. branchOp=1, X_Mreg_W=1, X_Mop1=F_Dop1=1 -> stall, hzd_cause=2. Same with X_Mop1=3 -> no stall. With X_Mreg_W=0 -> no stall.
4. branchOp=1, X_Mmem_R=1, X_Mop1=1 -> stall, hzd_cause=3. branchOp=1, M_Wmem_R=1, M_Wop1=1 -> stall, hzd_cause=4. Same with branchOp=0 -> no stall.
5. branch=1 concurrent with an LU hazard -> bubble=1, F_Dwrite=1, PCwrite=1; hzd_cause=5; flush_cnt +1 and stall_cnt unchanged.
6. Preload counters to the saturation value (CNT_W=2, hold stall for 5 cycles) -> stall_cnt stays at 3. Then pulse rst_n low between clock edges -> counters and hzd_cause read 0 immediately, and outputs read bubble=0, F_Dwrite=1, PCwrite=1 while rst_n is low.
